// File: rtl/sram_arb_ctrl.sv
// ---------------------------------------------------------------------------
// sram_arb_ctrl
//
// Arbitrates two classic Wishbone masters (8-bit data) onto one external
// asynchronous SRAM. Each access runs as SETUP -> ACCESS -> HOLD, so the
// address and write data are stable around every strobe. Ties are broken
// round-robin.
//
// Parameters:
//   ADDR_WIDTH  SRAM / Wishbone address width
//   RD_WAIT     cycles o_ram_oe_n is low per read  (1..15)
//   WR_WAIT     cycles o_ram_we_n is low per write (1..15)
//
// Ports:
//   i_clk, i_reset              clock, asynchronous active-high reset
//   i_mN_cyc/stb/we/addr/dat    Wishbone master N request (N = 0, 1)
//   o_mN_dat, o_mN_ack          Wishbone master N read data and acknowledge
//   o_ram_addr                  SRAM address
//   o_ram_ce_n/oe_n/we_n        SRAM chip, output and write enables
//   o_ram_dat, o_ram_dat_oe     write data and its pad output enable
//   i_ram_dat                   read data from the SRAM pads
//
// Every output comes straight from a register.
// ---------------------------------------------------------------------------
module sram_arb_ctrl #(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned RD_WAIT    = 2,
    parameter int unsigned WR_WAIT    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,

    input  logic                  i_m0_cyc,
    input  logic                  i_m0_stb,
    input  logic                  i_m0_we,
    input  logic [ADDR_WIDTH-1:0] i_m0_addr,
    input  logic [7:0]            i_m0_dat,
    output logic [7:0]            o_m0_dat,
    output logic                  o_m0_ack,

    input  logic                  i_m1_cyc,
    input  logic                  i_m1_stb,
    input  logic                  i_m1_we,
    input  logic [ADDR_WIDTH-1:0] i_m1_addr,
    input  logic [7:0]            i_m1_dat,
    output logic [7:0]            o_m1_dat,
    output logic                  o_m1_ack,

    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic                  o_ram_ce_n,
    output logic                  o_ram_oe_n,
    output logic                  o_ram_we_n,
    output logic [7:0]            o_ram_dat,
    output logic                  o_ram_dat_oe,
    input  logic [7:0]            i_ram_dat
);

    // Down-counter reload values: ACCESS lasts (reload + 1) cycles.
    localparam logic [3:0] RD_CNT = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_CNT = 4'(WR_WAIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StHold
    } state_t;

    state_t     state;
    logic       grant;       // port currently being served
    logic       last_grant;  // port served most recently, for round-robin
    logic       lat_we;      // latched write enable of the granted request
    logic [3:0] cnt;
    logic [7:0] rd_data;

    logic                  req0;
    logic                  req1;
    logic                  pick;
    logic                  pick_we;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [7:0]            pick_dat;

    // Arbitration: a lone requester wins; on a tie the port not served
    // last wins. Only consumed in StIdle.
    always_comb begin
        req0 = i_m0_cyc & i_m0_stb;
        req1 = i_m1_cyc & i_m1_stb;
        if (req0 && req1) begin
            pick = ~last_grant;
        end else begin
            pick = req1;
        end
        pick_we   = pick ? i_m1_we   : i_m0_we;
        pick_addr = pick ? i_m1_addr : i_m0_addr;
        pick_dat  = pick ? i_m1_dat  : i_m0_dat;
    end

    // Both masters see the same captured read data; only the acked one
    // is expected to use it.
    assign o_m0_dat = rd_data;
    assign o_m1_dat = rd_data;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= StIdle;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            lat_we       <= 1'b0;
            cnt          <= 4'd0;
            rd_data      <= 8'h00;
            o_m0_ack     <= 1'b0;
            o_m1_ack     <= 1'b0;
            o_ram_addr   <= '0;
            o_ram_ce_n   <= 1'b1;
            o_ram_oe_n   <= 1'b1;
            o_ram_we_n   <= 1'b1;
            o_ram_dat    <= 8'h00;
            o_ram_dat_oe <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (req0 || req1) begin
                        grant        <= pick;
                        last_grant   <= pick;
                        lat_we       <= pick_we;
                        // Address and write data are registered straight
                        // into the pin registers and held until HOLD ends.
                        o_ram_addr   <= pick_addr;
                        o_ram_dat    <= pick_dat;
                        o_ram_ce_n   <= 1'b0;
                        o_ram_dat_oe <= pick_we;
                        state        <= StSetup;
                    end
                end

                StSetup: begin
                    o_ram_oe_n <= lat_we;
                    o_ram_we_n <= ~lat_we;
                    cnt        <= lat_we ? WR_CNT : RD_CNT;
                    state      <= StAccess;
                end

                StAccess: begin
                    if (cnt == 4'd0) begin
                        o_ram_oe_n <= 1'b1;
                        o_ram_we_n <= 1'b1;
                        if (!lat_we) begin
                            rd_data <= i_ram_dat;
                        end
                        // A master that dropped cyc mid-access gets no ack,
                        // but the SRAM cycle has still run to completion.
                        o_m0_ack <= ~grant & i_m0_cyc;
                        o_m1_ack <= grant & i_m1_cyc;
                        state    <= StHold;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                StHold: begin
                    o_m0_ack     <= 1'b0;
                    o_m1_ack     <= 1'b0;
                    o_ram_ce_n   <= 1'b1;
                    o_ram_dat_oe <= 1'b0;
                    state        <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_arb_ctrl
//
// Directed bench for sram_arb_ctrl. Instance a uses default parameters,
// instance b uses RD_WAIT=5 / WR_WAIT=1. Each has its own SRAM model.
// One set of master drivers is steered to either instance by use_b.
// Per-cycle behaviour is recorded as bit masks (bit k = cycle k, where
// cycle 0 is the cycle the request is first presented).
// ---------------------------------------------------------------------------
module tb_sram_arb_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic load;
    logic use_b;

    logic        m0_cyc, m0_stb, m0_we;
    logic [23:0] m0_addr;
    logic [7:0]  m0_dat;
    logic        m1_cyc, m1_stb, m1_we;
    logic [23:0] m1_addr;
    logic [7:0]  m1_dat;

    logic [7:0]  a_m0_dat, a_m1_dat, b_m0_dat, b_m1_dat;
    logic        a_m0_ack, a_m1_ack, b_m0_ack, b_m1_ack;
    logic [23:0] a_addr, b_addr;
    logic        a_ce_n, a_oe_n, a_we_n, a_doe;
    logic        b_ce_n, b_oe_n, b_we_n, b_doe;
    logic [7:0]  a_dout, b_dout, a_din, b_din;

    sram_arb_ctrl u_dut_a (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_m0_cyc     (m0_cyc & ~use_b),
        .i_m0_stb     (m0_stb & ~use_b),
        .i_m0_we      (m0_we),
        .i_m0_addr    (m0_addr),
        .i_m0_dat     (m0_dat),
        .o_m0_dat     (a_m0_dat),
        .o_m0_ack     (a_m0_ack),
        .i_m1_cyc     (m1_cyc & ~use_b),
        .i_m1_stb     (m1_stb & ~use_b),
        .i_m1_we      (m1_we),
        .i_m1_addr    (m1_addr),
        .i_m1_dat     (m1_dat),
        .o_m1_dat     (a_m1_dat),
        .o_m1_ack     (a_m1_ack),
        .o_ram_addr   (a_addr),
        .o_ram_ce_n   (a_ce_n),
        .o_ram_oe_n   (a_oe_n),
        .o_ram_we_n   (a_we_n),
        .o_ram_dat    (a_dout),
        .o_ram_dat_oe (a_doe),
        .i_ram_dat    (a_din)
    );

    sram_arb_ctrl #(
        .ADDR_WIDTH (24),
        .RD_WAIT    (5),
        .WR_WAIT    (1)
    ) u_dut_b (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_m0_cyc     (m0_cyc & use_b),
        .i_m0_stb     (m0_stb & use_b),
        .i_m0_we      (m0_we),
        .i_m0_addr    (m0_addr),
        .i_m0_dat     (m0_dat),
        .o_m0_dat     (b_m0_dat),
        .o_m0_ack     (b_m0_ack),
        .i_m1_cyc     (m1_cyc & use_b),
        .i_m1_stb     (m1_stb & use_b),
        .i_m1_we      (m1_we),
        .i_m1_addr    (m1_addr),
        .i_m1_dat     (m1_dat),
        .o_m1_dat     (b_m1_dat),
        .o_m1_ack     (b_m1_ack),
        .o_ram_addr   (b_addr),
        .o_ram_ce_n   (b_ce_n),
        .o_ram_oe_n   (b_oe_n),
        .o_ram_we_n   (b_we_n),
        .o_ram_dat    (b_dout),
        .o_ram_dat_oe (b_doe),
        .i_ram_dat    (b_din)
    );

    // SRAM models: 64 KiB each, indexed by the low address bits.
    logic [7:0] mem_a [0:65535];
    logic [7:0] mem_b [0:65535];

    always @(posedge clk) begin
        if (load) begin
            mem_a[16'h1234] <= 8'hA5;
            mem_a[16'h0010] <= 8'h5A;
            mem_b[16'h1234] <= 8'hA5;
        end else begin
            if (!a_ce_n && !a_we_n) mem_a[a_addr[15:0]] <= a_dout;
            if (!b_ce_n && !b_we_n) mem_b[b_addr[15:0]] <= b_dout;
        end
    end

    assign a_din = mem_a[a_addr[15:0]];
    assign b_din = mem_b[b_addr[15:0]];

    // Signals of whichever instance is under test.
    logic        s_ce_n, s_oe_n, s_we_n, s_doe, s_ack0, s_ack1;
    logic [7:0]  s_m0_dat, s_m1_dat;
    logic [23:0] s_addr;
    assign s_ce_n   = use_b ? b_ce_n   : a_ce_n;
    assign s_oe_n   = use_b ? b_oe_n   : a_oe_n;
    assign s_we_n   = use_b ? b_we_n   : a_we_n;
    assign s_doe    = use_b ? b_doe    : a_doe;
    assign s_ack0   = use_b ? b_m0_ack : a_m0_ack;
    assign s_ack1   = use_b ? b_m1_ack : a_m1_ack;
    assign s_m0_dat = use_b ? b_m0_dat : a_m0_dat;
    assign s_m1_dat = use_b ? b_m1_dat : a_m1_dat;
    assign s_addr   = use_b ? b_addr   : a_addr;

    // Invariant monitor over both instances.
    int viol = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (!a_oe_n && !a_we_n) viol++;
            if (a_doe && !a_oe_n) viol++;
            if (a_m0_ack && a_m1_ack) viol++;
            if (!b_oe_n && !b_we_n) viol++;
            if (b_doe && !b_oe_n) viol++;
            if (b_m0_ack && b_m1_ack) viol++;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [31:0] t_oe, t_we, t_ce, t_doe, t_ack0, t_ack1;
    logic [7:0]  t_rd0, t_rd1;
    logic [23:0] t_addr0;

    // Present requests at cycle 0, record ncyc cycles. A master drops its
    // request once acked; port 0 also drops at cycle abort0 (-1: never).
    task automatic run_trace(input bit r0, input bit r1, input int abort0, input int ncyc);
        t_oe = '0; t_we = '0; t_ce = '0; t_doe = '0; t_ack0 = '0; t_ack1 = '0;
        t_rd0 = 8'h00; t_rd1 = 8'h00; t_addr0 = '0;
        @(posedge clk);
        #1;
        m0_cyc = r0; m0_stb = r0;
        m1_cyc = r1; m1_stb = r1;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (!s_oe_n) t_oe[k] = 1'b1;
            if (!s_we_n) t_we[k] = 1'b1;
            if (!s_ce_n) t_ce[k] = 1'b1;
            if (s_doe)   t_doe[k] = 1'b1;
            if (s_ack0) begin
                t_ack0[k] = 1'b1;
                t_rd0     = s_m0_dat;
                t_addr0   = s_addr;
                m0_cyc = 1'b0; m0_stb = 1'b0;
            end
            if (s_ack1) begin
                t_ack1[k] = 1'b1;
                t_rd1     = s_m1_dat;
                m1_cyc = 1'b0; m1_stb = 1'b0;
            end
            if (k == abort0) begin
                m0_cyc = 1'b0; m0_stb = 1'b0;
            end
        end
        m0_cyc = 1'b0; m0_stb = 1'b0;
        m1_cyc = 1'b0; m1_stb = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; load = 1'b1; use_b = 1'b0;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = '0; m0_dat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = '0; m1_dat = '0;

        #1;
        check("rst_ce_n", a_ce_n, 1);
        check("rst_oe_n", a_oe_n, 1);
        check("rst_we_n", a_we_n, 1);
        check("rst_dat_oe", a_doe, 0);
        check("rst_addr", a_addr, 0);
        check("rst_ram_dat", a_dout, 0);
        check("rst_acks", {a_m0_ack, a_m1_ack}, 0);
        check("rst_m0_dat", a_m0_dat, 0);

        repeat (2) @(posedge clk);
        #1;
        load = 1'b0;
        rst  = 1'b0;

        // Read, port 0.
        m0_we = 0; m0_addr = 24'h001234;
        run_trace(1, 0, -1, 8);
        check("rd_oe_mask", t_oe, 32'h0C);
        check("rd_ce_mask", t_ce, 32'h1E);
        check("rd_we_mask", t_we, 0);
        check("rd_doe_mask", t_doe, 0);
        check("rd_ack0", t_ack0, 32'h10);
        check("rd_ack1", t_ack1, 0);
        check("rd_data", t_rd0, 8'hA5);
        check("rd_addr", t_addr0, 24'h001234);

        // Write, port 1.
        m1_we = 1; m1_addr = 24'h00FFFF; m1_dat = 8'h3C;
        run_trace(0, 1, -1, 8);
        check("wr_doe_mask", t_doe, 32'h1E);
        check("wr_we_mask", t_we, 32'h0C);
        check("wr_oe_mask", t_oe, 0);
        check("wr_ack1", t_ack1, 32'h10);
        check("wr_ack0", t_ack0, 0);
        check("wr_mem", mem_a[16'hFFFF], 8'h3C);

        // Ties: port 0 first twice, then after a lone port 0 read, port 1 first.
        m0_we = 0; m0_addr = 24'h001234;
        m1_we = 0; m1_addr = 24'h000010;
        run_trace(1, 1, -1, 12);
        check("tie1_ack0", t_ack0, 32'h010);
        check("tie1_ack1", t_ack1, 32'h200);
        check("tie1_ce", t_ce, 32'h3DE);
        check("tie1_oe", t_oe, 32'h18C);
        check("tie1_rd0", t_rd0, 8'hA5);
        check("tie1_rd1", t_rd1, 8'h5A);
        run_trace(1, 1, -1, 12);
        check("tie2_ack0", t_ack0, 32'h010);
        check("tie2_ack1", t_ack1, 32'h200);
        run_trace(1, 0, -1, 8);
        check("solo_ack0", t_ack0, 32'h10);
        run_trace(1, 1, -1, 12);
        check("tie3_ack1", t_ack1, 32'h010);
        check("tie3_ack0", t_ack0, 32'h200);
        check("tie3_rd0", t_rd0, 8'hA5);

        // Reset in cycle 2 of a write.
        m1_we = 1; m1_addr = 24'h000020; m1_dat = 8'h77;
        @(posedge clk);
        #1;
        m1_cyc = 1; m1_stb = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_wr_we_n", a_we_n, 0);
        rst = 1'b1;
        #1;
        check("rstw_we_n", a_we_n, 1);
        check("rstw_ce_n", a_ce_n, 1);
        check("rstw_doe", a_doe, 0);
        m1_cyc = 0; m1_stb = 0;
        @(negedge clk);
        check("rstw_acks", {a_m0_ack, a_m1_ack}, 0);
        check("rstw_addr", a_addr, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m0_we = 0; m0_addr = 24'h00FFFF;
        run_trace(1, 0, -1, 8);
        check("post_rst_ack0", t_ack0, 32'h10);
        check("post_rst_rd", t_rd0, 8'h3C);

        // Port 0 aborts during ACCESS.
        m0_addr = 24'h001234;
        run_trace(1, 0, 2, 8);
        check("abort_oe", t_oe, 32'h0C);
        check("abort_ce", t_ce, 32'h1E);
        check("abort_ack0", t_ack0, 0);
        m0_addr = 24'h000010;
        run_trace(1, 0, -1, 8);
        check("after_abort_ack0", t_ack0, 32'h10);
        check("after_abort_rd", t_rd0, 8'h5A);

        // Instance b: RD_WAIT=5, WR_WAIT=1.
        use_b = 1'b1;
        m0_we = 0; m0_addr = 24'h001234;
        run_trace(1, 0, -1, 10);
        check("b_rd_ack0", t_ack0, 32'h80);
        check("b_rd_oe", t_oe, 32'h7C);
        check("b_rd_ce", t_ce, 32'hFE);
        check("b_rd_data", t_rd0, 8'hA5);
        m1_we = 1; m1_addr = 24'h00FFFF; m1_dat = 8'h3C;
        run_trace(0, 1, -1, 8);
        check("b_wr_ack1", t_ack1, 32'h08);
        check("b_wr_we", t_we, 32'h04);
        check("b_wr_doe", t_doe, 32'h0E);
        check("b_wr_oe", t_oe, 0);
        check("b_wr_mem", mem_b[16'hFFFF], 8'h3C);

        check("invariants", viol, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
